// File: rtl/dpram_arb_pkg.sv
// Shared defaults, state encoding and sizing helper for the DPRAM port-2 arbiter.
package dpram_arb_pkg;

    localparam int NREQ_DEF      = 4;
    localparam int AW_DEF        = 8;
    localparam int DW_DEF        = 16;
    localparam int MAX_BURST_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Beat counter must hold values 0..MAX_BURST.
    function automatic int cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set req bit at or after ptr.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   idx,
    output logic            found
);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_j;

    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        w_sum = '0;
        w_j   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr < NREQ, so a single subtraction wraps the search index.
            w_sum = {1'b0, ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NREQ))
                w_sum = w_sum - (PW+1)'(NREQ);
            w_j = w_sum[PW-1:0];
            if (!found && req[w_j]) begin
                found    = 1'b1;
                win[w_j] = 1'b1;
                idx      = w_j;
            end
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing RAM port 2 among NREQ cores; one beat per granted
// cycle, ack and read data one cycle after each beat.
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_din,
    input  logic [DW-1:0]      ram_dout,
    output logic               ram_rd,
    output logic               ram_wr
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = cnt_w(MAX_BURST);

    state_t          r_state;
    logic [NREQ-1:0] r_gnt;
    logic [PW-1:0]   r_gidx;
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_din;
    logic            r_ack_vld;
    logic [PW-1:0]   r_ack_idx;
    logic            r_ack_rd;
    logic [DW-1:0]   r_rdata;

    logic [AW-1:0]   w_addr_a  [NREQ];
    logic [DW-1:0]   w_wdata_a [NREQ];
    logic [NREQ-1:0] w_win;
    logic [PW-1:0]   w_widx;
    logic [PW-1:0]   w_nptr;
    logic            w_found;
    logic            w_beat;
    logic            w_we;
    logic            w_last;
    logic            w_others;
    logic            w_rd_ack;

    for (genvar i = 0; i < NREQ; i++) begin : g_split
        assign w_addr_a[i]  = addr[i*AW +: AW];
        assign w_wdata_a[i] = wdata[i*DW +: DW];
    end

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .win   (w_win),
        .idx   (w_widx),
        .found (w_found)
    );

    assign w_nptr   = (w_widx == PW'(NREQ-1)) ? '0 : w_widx + 1'b1;
    assign w_beat   = (r_state == BUSY) && req[r_gidx];
    assign w_we     = we[r_gidx];
    assign w_last   = (r_cnt == CW'(MAX_BURST-1));
    assign w_others = |(req & ~r_gnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= BUSY;
                        r_gnt   <= w_win;
                        r_gidx  <= w_widx;
                        r_cnt   <= '0;
                        r_ptr   <= w_nptr;
                    end
                end
                BUSY: begin
                    if (!w_beat) begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                    end else if (w_last) begin
                        // Burst limit only ends the grant when someone else is waiting.
                        r_cnt <= '0;
                        if (w_others) begin
                            r_state <= IDLE;
                            r_gnt   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_din     <= '0;
            r_ack_vld <= 1'b0;
            r_ack_idx <= '0;
            r_ack_rd  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (w_beat) begin
                r_addr <= w_addr_a[r_gidx];
                r_din  <= w_wdata_a[r_gidx];
            end
            r_ack_vld <= w_beat;
            r_ack_idx <= r_gidx;
            r_ack_rd  <= w_beat && !w_we;
            if (w_rd_ack)
                r_rdata <= ram_dout;
        end
    end

    assign w_rd_ack = r_ack_vld && r_ack_rd;

    assign gnt      = r_gnt;
    assign ack      = r_ack_vld ? (NREQ'(1) << r_ack_idx) : '0;
    assign rdata    = w_rd_ack ? ram_dout : r_rdata;
    assign ram_addr = w_beat ? w_addr_a[r_gidx]  : r_addr;
    assign ram_din  = w_beat ? w_wdata_a[r_gidx] : r_din;
    assign ram_rd   = w_beat && !w_we;
    assign ram_wr   = w_beat && w_we;

endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Round-robin arbiter that shares port 2 of the peripheral dual-port RAM among up to NREQ peripheral cores. The J1 CPU keeps exclusive use of port 1. Each core issues single-word reads and writes through a req/gnt/ack handshake. The arbiter multiplexes one core at a time onto the RAM port 2 signals (`addr_2`, `d_in_2`, `d_out_2`, `rd_2`, `wr_2`) and returns read data with fixed latency.

## Interface
- NREQ, 4, number of requesting cores (2..8)
- AW, 8, RAM address width
- DW, 16, RAM data width
- MAX_BURST, 8, beats a core may issue per grant when another core is waiting (1..255)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-core access request
- we  in  NREQ  per-core write enable (1 = write, 0 = read)
- addr  in  NREQ*AW  per-core address, core i at [i*AW +: AW]
- wdata  in  NREQ*DW  per-core write data, core i at [i*DW +: DW]
- gnt  out  NREQ  one-hot grant, registered
- ack  out  NREQ  one-cycle pulse, one per completed beat
- rdata  out  DW  read data, shared; valid only with ack of a read
- ram_addr  out  AW  to RAM addr_2
- ram_din  out  DW  to RAM d_in_2
- ram_dout  in  DW  from RAM d_out_2; valid the cycle after ram_rd
- ram_rd  out  1  to RAM rd_2
- ram_wr  out  1  to RAM wr_2

## Operation
- States: IDLE (no grant) and BUSY (exactly one gnt bit set).
- IDLE: if any req is set, pick a core with a round-robin search starting at `ptr`. Register gnt for that core, go to BUSY, clear the beat counter `cnt`, and set `ptr` = (winner+1) mod NREQ.
- BUSY, core g granted, req[g]=1: issue one beat that cycle.
  - ram_addr and ram_din come from core g.
  - ram_wr = we[g]; ram_rd = !we[g].
  - cnt increments.
- BUSY, req[g]=0: issue no beat. Clear gnt and return to IDLE next cycle.
- BUSY, a beat issues with cnt reaching MAX_BURST:
  - If any other req is set: clear gnt and go to IDLE.
  - Otherwise: reset cnt to 0 and keep the grant.
- ram_rd and ram_wr are never both 1. Both are 0 in IDLE and on non-beat cycles. ram_addr and ram_din hold their last value when idle.
- Each beat produces ack[g] exactly one cycle after issue. For reads, rdata = ram_dout in that cycle. For writes, rdata holds its previous value.
- The ack pipeline is a one-stage register (beat valid, core index, read flag). It is independent of the grant, so a final-beat ack still fires after gnt has dropped.
- A core must hold addr, we and wdata stable while req=1 and gnt=0. Each gnt=1 cycle with req=1 consumes the current addr/we/wdata.
- Requests from non-granted cores are ignored until they win arbitration. Nothing is queued.

## Timing
- Reset values: gnt=0, ack=0, rdata=0, ram_rd=0, ram_wr=0, ram_addr=0, ram_din=0, state IDLE, ptr=0, cnt=0.
- Latency, starting from req[i] rising in cycle N while IDLE:
  - N+1: gnt[i]=1 and the first beat issues.
  - N+2: ack[i]=1 and read data appears on rdata.
- Sustained throughput: one beat per cycle while granted.
- Grant handover costs one IDLE cycle: gnt drops at edge E and the next grant is registered at E+1.
- Simultaneous requests are resolved by `ptr` only. There is no fixed priority beyond ptr=0 after reset.
- Reset asserted mid-burst: all outputs are forced to their reset values immediately (asynchronous). Any pending ack is discarded. After reset releases, arbitration restarts from core 0.
- A req change during the single ack cycle has no effect on that ack.

## Structure
- Package `dpram_arb_pkg`: defaults for AW, DW, NREQ, MAX_BURST; the state encoding (IDLE=1'b0, BUSY=1'b1); a function returning the width of cnt from MAX_BURST.
- Sub-module `rr_pick`: purely combinational round-robin priority encoder. Inputs are req[NREQ-1:0] and ptr. Outputs are a one-hot winner and its index, with found=0 when req is all zero.
- Top level holds the state register, grant register, beat counter, output mux and ack pipeline. Estimated size is about 200 lines.

## Test plan
- Single read: preload RAM[0x10]=0xBEEF. Core 2 pulses req with we=0, addr=0x10 at cycle 5. Expect gnt[2] at 6, ram_rd at 6, ack[2] at 7, rdata=0xBEEF; gnt=0 at 8.
- Write then read-back: core 0 writes 0x1234 to 0x20, then reads 0x20. Expect ram_wr for one cycle with ram_din=0x1234, then a read returning 0x1234 and exactly two ack[0] pulses.
- Fairness: all four reqs held high from reset release, single beat each (req dropped after the ack). Expect grant order 0,1,2,3,0 with one idle cycle between grants.
- Burst limit: core 1 holds req for 20 beats while core 3 requests at beat 2. Expect exactly 8 beats to core 1, a gnt handover to core 3, and no beat lost or duplicated. Also expect core 1 to stream all 20 beats uninterrupted when it is alone.
- Reset mid-burst: assert rst during beat 3 of a core 0 burst. Expect gnt, ack, ram_rd and ram_wr at 0 within the same cycle. After release, expect core 0 to regain the grant first when all cores request.
- Exclusivity check: randomized req/we over 10k cycles with an assertion that gnt is one-hot or zero and ram_rd & ram_wr is never 1. A scoreboard confirms the count of ack pulses equals the count of issued beats.
